// File: rtl/soda_pkg.sv
// Shared types and default parameter values for the soda dispenser controller.
package soda_pkg;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        WAIT   = 3'd1,
        ADD    = 3'd2,
        DISP   = 3'd3,
        REFUND = 3'd4
    } state_t;

    localparam int DEF_DISP_CYCLES    = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1000;
    localparam int DEF_TIMER_W        = 10;

endpackage

// File: rtl/soda_if.sv
// Control/status link between the soda controller and the SodaDatapath.
interface soda_if;

    logic tot_ld;
    logic tot_clr;
    logic tot_lt_s;

    modport master (output tot_ld, output tot_clr, input tot_lt_s);
    modport slave  (input tot_ld, input tot_clr, output tot_lt_s);

endinterface

// File: rtl/soda_timer.sv
// Up-counter with synchronous clear and enable, shared by the idle-timeout
// and dispense-hold functions of the controller.
module soda_timer #(
    parameter int TIMER_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    output logic [TIMER_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/soda_controller.sv
// Soda dispenser control FSM: coin edge detect, one-deep coin buffer,
// dispense hold and idle-credit refund, driving the datapath via soda_if.
module soda_controller
    import soda_pkg::*;
#(
    parameter int DISP_CYCLES    = DEF_DISP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TIMER_W        = DEF_TIMER_W
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   c,
    soda_if.master dp,
    output logic   d,
    output logic   refund,
    output logic   coin_reject,
    output logic   busy
);

    localparam logic [TIMER_W-1:0] DISP_LAST    = TIMER_W'(DISP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t               state;
    state_t               state_next;
    logic                 c_q;
    logic                 coin_rise;
    logic                 pending;
    logic                 pending_next;
    logic                 credit;
    logic                 credit_next;
    logic                 reject_next;
    logic                 buffer_coin;
    logic                 timer_clr;
    logic                 timer_en;
    logic [TIMER_W-1:0]   timer;

    assign coin_rise = c & ~c_q;

    soda_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .count (timer)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            c_q         <= 1'b0;
            pending     <= 1'b0;
            credit      <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_next;
            c_q         <= c;
            pending     <= pending_next;
            credit      <= credit_next;
            coin_reject <= reject_next;
        end
    end

    always_comb begin
        state_next   = state;
        pending_next = pending;
        credit_next  = credit;
        reject_next  = 1'b0;
        buffer_coin  = 1'b0;
        timer_clr    = 1'b0;
        timer_en     = 1'b0;

        case (state)
            INIT: begin
                credit_next = 1'b0;
                timer_clr   = 1'b1;
                buffer_coin = coin_rise;
                state_next  = WAIT;
            end
            WAIT: begin
                if (!dp.tot_lt_s) begin
                    timer_clr   = 1'b1;
                    buffer_coin = coin_rise;
                    state_next  = DISP;
                end else if (coin_rise | pending) begin
                    // A fresh edge arriving while the buffered coin is consumed takes its slot.
                    pending_next = pending & coin_rise;
                    timer_clr    = 1'b1;
                    state_next   = ADD;
                end else if (credit && (timer == TIMEOUT_LAST)) begin
                    state_next = REFUND;
                end else begin
                    timer_en = credit;
                end
            end
            ADD: begin
                credit_next = 1'b1;
                buffer_coin = coin_rise;
                state_next  = WAIT;
            end
            DISP: begin
                timer_en    = 1'b1;
                buffer_coin = coin_rise;
                if (timer == DISP_LAST) begin
                    state_next = INIT;
                end
            end
            REFUND: begin
                buffer_coin = coin_rise;
                state_next  = INIT;
            end
            default: begin
                state_next = INIT;
            end
        endcase

        if (buffer_coin) begin
            if (pending) begin
                reject_next = 1'b1;
            end else begin
                pending_next = 1'b1;
            end
        end
    end

    assign dp.tot_clr = (state == INIT);
    assign dp.tot_ld  = (state == ADD);
    assign d          = (state == DISP);
    assign refund     = (state == REFUND);
    assign busy       = (state != WAIT);

endmodule

// File: tb/tb_soda_controller.sv
// Self-checking bench: controller plus a behavioural datapath, compared every
// cycle against a phase/countdown reference model of the dispenser rules.
module tb_soda_controller;

    localparam int DISP_CYCLES    = 4;
    localparam int TIMEOUT_CYCLES = 20;

    localparam int PH_CLEAR  = 0;
    localparam int PH_IDLE   = 1;
    localparam int PH_LOAD   = 2;
    localparam int PH_POUR   = 3;
    localparam int PH_RETURN = 4;

    logic       clk;
    logic       rst_n;
    logic       c;
    logic       d;
    logic       refund;
    logic       coin_reject;
    logic       busy;
    logic [8:0] price;
    logic [8:0] a_val;
    logic [8:0] total = '0;

    int vectors     = 0;
    int miscompares = 0;

    int   m_mode;
    int   m_idle;
    int   m_pour_left;
    int   m_total;
    logic m_pending;
    logic m_credit;
    logic m_cq;
    logic m_reject;

    int ld_seen;
    int d_seen;
    int refund_seen;
    int reject_seen;

    int coin_vals [5] = '{5, 10, 25, 50, 100};

    soda_if dp_if ();

    soda_controller #(
        .DISP_CYCLES    (DISP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMER_W        (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .c           (c),
        .dp          (dp_if),
        .d           (d),
        .refund      (refund),
        .coin_reject (coin_reject),
        .busy        (busy)
    );

    // Behavioural SodaDatapath: 9-bit running total compared against the price.
    assign dp_if.tot_lt_s = (total < price);

    always @(posedge clk) begin
        if (dp_if.tot_clr) begin
            total <= '0;
        end else if (dp_if.tot_ld) begin
            total <= total + a_val;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
        end
    endtask

    function automatic logic [5:0] dutVec();
        return {dp_if.tot_clr, dp_if.tot_ld, d, refund, coin_reject, busy};
    endfunction

    function automatic logic [5:0] expVec();
        return {m_mode == PH_CLEAR, m_mode == PH_LOAD, m_mode == PH_POUR,
                m_mode == PH_RETURN, m_reject, m_mode != PH_IDLE};
    endfunction

    function automatic void modelReset();
        m_mode      = PH_CLEAR;
        m_idle      = 0;
        m_pour_left = 0;
        m_total     = 0;
        m_pending   = 1'b0;
        m_credit    = 1'b0;
        m_cq        = 1'b0;
        m_reject    = 1'b0;
    endfunction

    // One clock of the dispenser rules, applied with the coin level seen this cycle.
    function automatic void modelStep(input logic cin);
        logic rise;
        logic lt;
        logic to_buffer;
        int   nxt;
        rise      = cin && !m_cq;
        lt        = (m_total < int'(price));
        to_buffer = 1'b0;
        nxt       = m_mode;
        m_reject  = 1'b0;
        case (m_mode)
            PH_CLEAR: begin
                m_credit  = 1'b0;
                m_idle    = 0;
                m_total   = 0;
                to_buffer = rise;
                nxt       = PH_IDLE;
            end
            PH_IDLE: begin
                if (!lt) begin
                    m_pour_left = DISP_CYCLES;
                    to_buffer   = rise;
                    nxt         = PH_POUR;
                end else if (rise || m_pending) begin
                    m_pending = m_pending && rise;
                    m_idle    = 0;
                    nxt       = PH_LOAD;
                end else if (m_credit && m_idle == TIMEOUT_CYCLES - 1) begin
                    nxt = PH_RETURN;
                end else if (m_credit) begin
                    m_idle++;
                end
            end
            PH_LOAD: begin
                m_credit  = 1'b1;
                m_total   = (m_total + int'(a_val)) % 512;
                to_buffer = rise;
                nxt       = PH_IDLE;
            end
            PH_POUR: begin
                m_pour_left--;
                to_buffer = rise;
                if (m_pour_left == 0) nxt = PH_CLEAR;
            end
            default: begin
                to_buffer = rise;
                nxt       = PH_CLEAR;
            end
        endcase
        if (to_buffer) begin
            if (m_pending) m_reject = 1'b1;
            else           m_pending = 1'b1;
        end
        m_cq   = cin;
        m_mode = nxt;
    endfunction

    task automatic compareCycle();
        checkOutput("outputs", 32'(dutVec()), 32'(expVec()));
        checkOutput("total", 32'(total), 32'(m_total));
        if (dp_if.tot_ld) ld_seen++;
        if (d)            d_seen++;
        if (refund)       refund_seen++;
        if (coin_reject)  reject_seen++;
    endtask

    task automatic clearSeen();
        ld_seen     = 0;
        d_seen      = 0;
        refund_seen = 0;
        reject_seen = 0;
    endtask

    task automatic applyStimulus(input logic coin);
        c = coin;
        modelStep(coin);
        @(posedge clk);
        @(negedge clk);
        compareCycle();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0);
    endtask

    task automatic insertCoin(input int gap);
        applyStimulus(1'b1);
        idle(gap);
    endtask

    task automatic assertReset();
        rst_n = 1'b0;
        c     = 1'b0;
        #1;
        checkOutput("reset_outputs", 32'(dutVec()), 32'(6'b100001));
        repeat (2) @(posedge clk);
        @(negedge clk);
        modelReset();
        rst_n = 1'b1;
        compareCycle();
        clearSeen();
    endtask

    task automatic doReset();
        @(negedge clk);
        assertReset();
    endtask

    initial begin
        int idle_left;
        rst_n = 1'b0;
        c     = 1'b0;
        price = '0;
        a_val = '0;
        clearSeen();
        modelReset();

        // Three 25 coins against a price of 75.
        price = 9'd75; a_val = 9'd25;
        doReset();
        idle(2);
        repeat (3) insertCoin(4);
        idle(15);
        checkOutput("s1_ld_count", 32'(ld_seen), 32'd3);
        checkOutput("s1_d_cycles", 32'(d_seen), 32'd4);
        checkOutput("s1_busy_end", 32'(busy), 32'd0);

        // 25 then 50 against a price of 50.
        price = 9'd50;
        doReset();
        idle(2);
        a_val = 9'd25; insertCoin(4);
        a_val = 9'd50; insertCoin(15);
        checkOutput("s2_d_cycles", 32'(d_seen), 32'd4);
        checkOutput("s2_no_refund", 32'(refund_seen), 32'd0);

        // Single coin then idle: refund after the timeout.
        price = 9'd100; a_val = 9'd25;
        doReset();
        idle(2);
        insertCoin(30);
        checkOutput("s3_refund_count", 32'(refund_seen), 32'd1);
        checkOutput("s3_total_cleared", 32'(total), 32'd0);

        // Two rising edges during dispense: one buffered, one rejected.
        price = 9'd25; a_val = 9'd25;
        doReset();
        idle(2);
        applyStimulus(1'b1); idle(3);
        applyStimulus(1'b1); applyStimulus(1'b0);
        applyStimulus(1'b1); idle(21);
        checkOutput("s4_reject_count", 32'(reject_seen), 32'd1);
        checkOutput("s4_d_cycles", 32'(d_seen), 32'd8);
        checkOutput("s4_ld_count", 32'(ld_seen), 32'd2);

        // Asynchronous reset in the middle of a dispense.
        doReset();
        idle(2);
        applyStimulus(1'b1); idle(3);
        checkOutput("s5_disp_before_rst", 32'(d), 32'd1);
        #2;
        assertReset();
        idle(10);
        checkOutput("s5_total_after_rst", 32'(total), 32'd0);
        checkOutput("s5_idle_after_rst", 32'(busy), 32'd0);

        // Zero price dispenses without coins and never refunds.
        price = 9'd0;
        doReset();
        idle(30);
        checkOutput("s6_dispensed", 32'(d_seen != 0), 32'd1);
        checkOutput("s6_no_refund", 32'(refund_seen), 32'd0);

        // Randomised sessions with mixed coin values and idle stretches.
        for (int s = 0; s < 6; s++) begin
            price = 9'(25 * $urandom_range(1, 8));
            doReset();
            idle_left = 0;
            for (int i = 0; i < 250; i++) begin
                a_val = 9'(coin_vals[$urandom_range(0, 4)]);
                if (idle_left > 0) begin
                    idle_left--;
                    applyStimulus(1'b0);
                end else begin
                    if ($urandom_range(0, 19) == 0) idle_left = 25;
                    applyStimulus(1'($urandom_range(0, 1)));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/soda_controller.md
# soda_controller

Control unit for the soda dispenser. It sequences `SodaDatapath` through its `tot_clr` and `tot_ld` controls and reads back `tot_lt_s`. It counts inserted coins, asserts the dispense output once the running total reaches the price, and returns the credit if the customer goes idle. Coins arriving while the controller is busy are buffered one deep; any further coin is rejected.

## Interface
Parameters:
- `DISP_CYCLES`, default 4: number of cycles `d` is held high per dispense (≥1).
- `TIMEOUT_CYCLES`, default 1000: idle cycles in WAIT, with credit present, before a refund (≥2).
- `TIMER_W`, default 10: timer width; must satisfy 2^TIMER_W ≥ max(DISP_CYCLES, TIMEOUT_CYCLES).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `c` in 1: coin-present level, synchronous to `clk`. Each rising edge is one coin.
- `tot_lt_s` in 1: from datapath; total < price.
- `tot_ld` out 1: to datapath; add coin value `a` to the total.
- `tot_clr` out 1: to datapath; clear the total.
- `d` out 1: dispense soda.
- `refund` out 1: one-cycle pulse; the coin mechanism returns the current total.
- `coin_reject` out 1: one-cycle pulse; return the coin just inserted.
- `busy` out 1: high in every state except WAIT.

## Operation
- Edge detect: `c_q <= c`; `coin_rise = c & ~c_q`. `c_q` resets to 0.
- States: INIT, WAIT, ADD, DISP, REFUND.
- INIT:
  - `tot_clr`=1; clear `credit` and the timer.
  - Next state is WAIT.
- WAIT, evaluated in this priority order:
  - (1) `!tot_lt_s` → DISP.
  - (2) `coin_rise | pending` → ADD; clear `pending`.
  - (3) `credit` and timer == TIMEOUT_CYCLES-1 → REFUND.
  - Otherwise stay in WAIT. The timer increments while `credit`=1 and resets on every coin accepted.
- ADD:
  - `tot_ld`=1 for exactly one cycle; set `credit`.
  - Next state is WAIT. The updated `tot_lt_s` is valid in that WAIT cycle.
- DISP:
  - `d`=1 for DISP_CYCLES cycles, counted by the timer.
  - Next state is INIT.
- REFUND:
  - `refund`=1 for one cycle.
  - Next state is INIT.
- Pending coin buffer:
  - A `coin_rise` in INIT, ADD, DISP or REFUND, or in WAIT while priority (1) fires, sets `pending`.
  - If `pending` is already set, that coin is not buffered and `coin_reject` pulses on the next cycle.
  - `pending` survives INIT, so a buffered coin counts toward the next purchase.
- Boundaries:
  - Price 0: `tot_lt_s`=0 right after INIT, so the controller dispenses with no coin. This is intended behaviour and the datapath owner is responsible for it.
  - Timeout never fires without credit.
  - Total overflow is a datapath concern (its total register is 9 bits wide).
- All datapath controls (`tot_ld`, `tot_clr`, `d`, `refund`) are Moore decodes of the state register. `busy` is also a state decode.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state=INIT, `pending`=0, `credit`=0, timer=0, `c_q`=0, `coin_reject`=0.
  - Outputs during reset: `tot_clr`=1, `busy`=1; `tot_ld`, `d`, `refund`, `coin_reject` are all 0.
- Deasserting reset mid-operation always restarts from INIT. The total is cleared on the first clock edge after release.
- Coin in WAIT to total updated takes 2 edges: the WAIT→ADD edge, then the ADD edge that loads the total.
- Final coin to `d` high:
  - `coin_rise` in WAIT, then ADD, then WAIT (where `tot_lt_s` falls), then DISP.
  - `d` first rises 3 cycles after the `coin_rise` cycle.
- Dispense completion: after DISP_CYCLES cycles in DISP, one INIT cycle, then back in WAIT.
- `coin_reject` is registered: one pulse, one cycle after the offending edge.

## Structure
- Package `soda_pkg`: `state_t` enum (INIT=0, WAIT=1, ADD=2, DISP=3, REFUND=4, 3-bit encoding) and the default-parameter constants.
- Sub-module `soda_timer`:
  - TIMER_W-bit up-counter with sync clear and enable; reset via `rst_n`.
  - Shared between the timeout and dispense-hold functions. The two uses are mutually exclusive by state.
- The FSM, edge detect and pending logic live in `soda_controller`.

## Test plan
All scenarios pair the controller with `SodaDatapath` and use DISP_CYCLES=4, TIMEOUT_CYCLES=20.
- Price s=75; coins a=25 at three separated edges → `tot_ld` pulses 3 times; `d` high exactly 4 cycles, starting 3 cycles after the third edge; `tot_clr` follows; `busy` returns to 0.
- s=50; coins a=25 then a=50 → dispenses after the second coin (total 75 ≥ 50); no refund pulse.
- s=100; a single 25 coin, then idle → `refund` pulses 20 cycles after entering WAIT with credit; the total is cleared.
- s=25; one coin accepted, then two more rising edges during DISP → the first is buffered (`pending`), the second gives a one-cycle `coin_reject`; after INIT the buffered coin is loaded and dispenses again.
- `rst_n` pulled low mid-DISP, asynchronously between clock edges → `d` drops immediately and `tot_clr`=1; after release the controller returns to WAIT with total 0.
- s=0 → `d` asserts with no coin; `refund` never asserts (no credit).
